// File: rtl/vga_fill_engine.sv
// Framebuffer command engine: register file on the 8-bit device bus plus a FILL/CLEAR/SWAP sequencer.
// Latency: a command starts 1 cycle after GO (SETUP), its first pixel is offered 2 cycles after GO, and it completes with a 1-cycle DONE.
// Backpressure: fb_we holds with fb_address/fb_data stable until fb_ready; one pixel retires per fb_we && fb_ready cycle.
//
// Ports:
//   clk, reset                      system clock, synchronous active-high reset
//   address/enable/mode/data_in     device bus (mode 1 = read, 0 = write)
//   data_out                        registered read data, driven only while enable && mode
//   interrupt                       bit 0 pulses in the DONE cycle, 'z otherwise
//   frame                           one-cycle vblank pulse used by SWAP
//   fb_we/fb_ready/fb_address/fb_data  pixel write port into the back buffer
//   current_frame                   buffer being written; the other one is displayed
//   busy                            a command is in progress
module vga_fill_engine #(
    parameter int FB_WIDTH        = 160,
    parameter int FB_HEIGHT       = 120,
    parameter int DATA_WIDTH      = 8,
    parameter int INTERRUPT_WIDTH = 4,
    localparam int FB_ADDRESS_WIDTH = $clog2(FB_WIDTH * FB_HEIGHT)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [3:0]                  address,
    input  logic                        enable,
    input  logic                        mode,
    input  logic [7:0]                  data_in,
    output logic [7:0]                  data_out,
    output logic [INTERRUPT_WIDTH-1:0]  interrupt,
    input  logic                        frame,
    output logic                        fb_we,
    input  logic                        fb_ready,
    output logic [FB_ADDRESS_WIDTH-1:0] fb_address,
    output logic [DATA_WIDTH-1:0]       fb_data,
    output logic                        current_frame,
    output logic                        busy
);

    localparam logic [16:0] FB_W17 = 17'(FB_WIDTH);
    localparam logic [16:0] FB_H17 = 17'(FB_HEIGHT);
    localparam logic [FB_ADDRESS_WIDTH-1:0] ROW_STEP = FB_ADDRESS_WIDTH'(FB_WIDTH);

    localparam logic [1:0] CMD_SWAP  = 2'd0;
    localparam logic [1:0] CMD_FILL  = 2'd1;
    localparam logic [1:0] CMD_CLEAR = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_FILL,
        S_WAIT_FRAME,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // programmable registers
    logic [7:0]  cmd_q;
    logic [15:0] x0_q, y0_q, w_q, h_q;
    logic [7:0]  color_q;
    logic        err_q;
    logic [7:0]  rd_q;

    // active command context, latched at GO / SETUP
    logic [1:0]  act_cmd;
    logic [15:0] cur_x, cur_y;
    logic [15:0] x_start, x_last, y_last;
    logic [FB_ADDRESS_WIDTH-1:0] row_addr;

    logic        wr, go_wr;
    logic        fill_last;
    logic [16:0] sum_x, sum_y;
    logic [16:0] clip_x0, clip_y0, clip_xe, clip_ye;
    logic        clip_empty;
    logic [31:0] start_lin;
    logic [7:0]  rd_mux;

    assign wr    = enable && !mode;
    assign go_wr = wr && (address == 4'd1);
    assign busy  = (state != S_IDLE);
    assign fb_we = (state == S_FILL);

    assign data_out  = (enable && mode) ? rd_q : 'z;
    assign interrupt = (state == S_DONE) ? INTERRUPT_WIDTH'(1) : 'z;

    assign fill_last = (cur_x == x_last) && (cur_y == y_last);

    // Clip in 17 bits so X0+W cannot wrap before the min().
    assign sum_x = {1'b0, x0_q} + {1'b0, w_q};
    assign sum_y = {1'b0, y0_q} + {1'b0, h_q};

    always_comb begin
        clip_x0    = 17'd0;
        clip_y0    = 17'd0;
        clip_xe    = FB_W17;
        clip_ye    = FB_H17;
        clip_empty = 1'b0;
        if (act_cmd == CMD_FILL) begin
            clip_x0    = {1'b0, x0_q};
            clip_y0    = {1'b0, y0_q};
            clip_xe    = (sum_x > FB_W17) ? FB_W17 : sum_x;
            clip_ye    = (sum_y > FB_H17) ? FB_H17 : sum_y;
            clip_empty = (w_q == 16'd0) || (h_q == 16'd0) ||
                         (clip_x0 >= FB_W17) || (clip_y0 >= FB_H17);
        end
    end

    // The only multiply: first-pixel address, used once in SETUP.
    assign start_lin = 32'(clip_y0) * 32'(FB_WIDTH) + 32'(clip_x0);

    always_comb begin
        rd_mux = 8'h00;
        case (address)
            4'd0:    rd_mux = cmd_q;
            4'd2:    rd_mux = x0_q[7:0];
            4'd3:    rd_mux = x0_q[15:8];
            4'd4:    rd_mux = y0_q[7:0];
            4'd5:    rd_mux = y0_q[15:8];
            4'd6:    rd_mux = w_q[7:0];
            4'd7:    rd_mux = w_q[15:8];
            4'd8:    rd_mux = h_q[7:0];
            4'd9:    rd_mux = h_q[15:8];
            4'd10:   rd_mux = color_q;
            4'd11:   rd_mux = {6'b0, err_q, busy};
            default: rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (go_wr) begin
                    // unknown commands finish at once so software still sees an interrupt
                    state_nxt = (cmd_q <= 8'd2) ? S_SETUP : S_DONE;
                end
            end
            S_SETUP: begin
                if (act_cmd == CMD_SWAP) begin
                    state_nxt = S_WAIT_FRAME;
                end else if (clip_empty) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (fb_ready && fill_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_WAIT_FRAME: begin
                if (frame) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q         <= 8'h00;
            x0_q          <= 16'h0000;
            y0_q          <= 16'h0000;
            w_q           <= 16'h0000;
            h_q           <= 16'h0000;
            color_q       <= 8'h00;
            err_q         <= 1'b0;
            rd_q          <= 8'h00;
            act_cmd       <= CMD_SWAP;
            cur_x         <= 16'h0000;
            cur_y         <= 16'h0000;
            x_start       <= 16'h0000;
            x_last        <= 16'h0000;
            y_last        <= 16'h0000;
            row_addr      <= '0;
            fb_address    <= '0;
            fb_data       <= '0;
            current_frame <= 1'b0;
        end else begin
            rd_q <= rd_mux;

            if (wr) begin
                case (address)
                    4'd0:  cmd_q        <= data_in;
                    4'd2:  x0_q[7:0]    <= data_in;
                    4'd3:  x0_q[15:8]   <= data_in;
                    4'd4:  y0_q[7:0]    <= data_in;
                    4'd5:  y0_q[15:8]   <= data_in;
                    4'd6:  w_q[7:0]     <= data_in;
                    4'd7:  w_q[15:8]    <= data_in;
                    4'd8:  h_q[7:0]     <= data_in;
                    4'd9:  h_q[15:8]    <= data_in;
                    4'd10: color_q      <= data_in;
                    4'd11: if (data_in[1]) err_q <= 1'b0;
                    default: ;
                endcase
            end

            // GO and STATUS are different addresses, so set and clear never collide.
            if (go_wr && ((state != S_IDLE) || (cmd_q > 8'd2))) begin
                err_q <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (go_wr) begin
                        act_cmd <= cmd_q[1:0];
                    end
                end
                S_SETUP: begin
                    cur_x      <= 16'(clip_x0);
                    cur_y      <= 16'(clip_y0);
                    x_start    <= 16'(clip_x0);
                    x_last     <= 16'(clip_xe - 17'd1);
                    y_last     <= 16'(clip_ye - 17'd1);
                    row_addr   <= FB_ADDRESS_WIDTH'(start_lin);
                    fb_address <= FB_ADDRESS_WIDTH'(start_lin);
                    fb_data    <= color_q[DATA_WIDTH-1:0];
                end
                S_FILL: begin
                    if (fb_ready && !fill_last) begin
                        if (cur_x == x_last) begin
                            // wrap to the next row: step the row base by one line
                            cur_x      <= x_start;
                            cur_y      <= cur_y + 16'd1;
                            row_addr   <= row_addr + ROW_STEP;
                            fb_address <= row_addr + ROW_STEP;
                        end else begin
                            cur_x      <= cur_x + 16'd1;
                            fb_address <= fb_address + 1'b1;
                        end
                    end
                end
                S_WAIT_FRAME: begin
                    if (frame) begin
                        current_frame <= ~current_frame;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_fill_engine.sv
module tb_vga_fill_engine;

    localparam int FBW  = 160;
    localparam int FBH  = 120;
    localparam int INTW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  address;
    logic        enable;
    logic        mode;
    logic [7:0]  data_in;
    wire  [7:0]  data_out;
    wire  [INTW-1:0] interrupt;
    logic        frame;
    logic        fb_we;
    logic        fb_ready;
    logic [14:0] fb_address;
    logic [7:0]  fb_data;
    logic        current_frame;
    logic        busy;

    vga_fill_engine #(
        .FB_WIDTH(FBW),
        .FB_HEIGHT(FBH),
        .DATA_WIDTH(8),
        .INTERRUPT_WIDTH(INTW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .enable(enable),
        .mode(mode),
        .data_in(data_in),
        .data_out(data_out),
        .interrupt(interrupt),
        .frame(frame),
        .fb_we(fb_we),
        .fb_ready(fb_ready),
        .fb_address(fb_address),
        .fb_data(fb_data),
        .current_frame(current_frame),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0;
    int pix_addr[$];
    int pix_data[$];
    int pix_cyc[$];
    int exp_addr[$];
    int irq_cnt = 0;
    int irq_cyc = -1;
    int stall_err = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: driven by the test
    logic        prev_stall = 1'b0;
    logic [14:0] prev_addr = '0;
    logic [7:0]  prev_data = '0;

    // Observer: records accepted pixels, interrupt pulses and stall stability.
    always @(negedge clk) begin
        cyc++;
        if (prev_stall && !(fb_we === 1'b1 && fb_address === prev_addr && fb_data === prev_data))
            stall_err++;
        prev_stall = (fb_we === 1'b1) && (fb_ready === 1'b0);
        prev_addr  = fb_address;
        prev_data  = fb_data;
        if (fb_we === 1'b1 && fb_ready === 1'b1) begin
            pix_addr.push_back(int'(fb_address));
            pix_data.push_back(int'(fb_data));
            pix_cyc.push_back(cyc);
        end
        if (interrupt[0] === 1'b1) begin
            irq_cnt++;
            irq_cyc = cyc;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) fb_ready = 1'b1;
            else if (ready_mode == 1) fb_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Reference: row-major list of clipped pixel addresses.
    function automatic void model_rect(input int x0, input int y0, input int w, input int h);
        int xe, ye;
        exp_addr.delete();
        xe = (x0 + w < FBW) ? x0 + w : FBW;
        ye = (y0 + h < FBH) ? y0 + h : FBH;
        for (int y = y0; y < ye; y++)
            for (int x = x0; x < xe; x++)
                exp_addr.push_back(y * FBW + x);
    endfunction

    // -2: count differs, -1: identical, otherwise first differing index
    function automatic int first_bad(input int color);
        if (pix_addr.size() != exp_addr.size()) return -2;
        foreach (exp_addr[i])
            if (pix_addr[i] != exp_addr[i] || pix_data[i] != color) return i;
        return -1;
    endfunction

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        address = a;
        data_in = d;
        mode    = 1'b0;
        enable  = 1'b1;
        @(posedge clk);
        #1;
        enable  = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        address = a;
        mode    = 1'b1;
        enable  = 1'b1;
        @(negedge clk);
        d       = data_out;
        enable  = 1'b0;
        mode    = 1'b0;
    endtask

    task automatic program_rect(input int x0, input int y0, input int w, input int h, input int color);
        bus_write(4'd2, 8'(x0));
        bus_write(4'd3, 8'(x0 >> 8));
        bus_write(4'd4, 8'(y0));
        bus_write(4'd5, 8'(y0 >> 8));
        bus_write(4'd6, 8'(w));
        bus_write(4'd7, 8'(w >> 8));
        bus_write(4'd8, 8'(h));
        bus_write(4'd9, 8'(h >> 8));
        bus_write(4'd10, 8'(color));
    endtask

    task automatic start_cmd(input int cmd, output int go_cyc, output int c0);
        bus_write(4'd0, 8'(cmd));
        pix_addr.delete();
        pix_data.delete();
        pix_cyc.delete();
        c0 = irq_cnt;
        bus_write(4'd1, 8'h5A);
        go_cyc = cyc;
    endtask

    task automatic wait_irq(input int c0, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (irq_cnt > c0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        reset = 1'b1; enable = 1'b0; mode = 1'b0; address = '0; data_in = '0; frame = 1'b0;
        fb_ready = 1'b1; ready_mode = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        n_tests++; if (fb_we !== 1'b0) begin n_fail++; $display("FAIL reset_fb_we: got %b, required 0", fb_we); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_tests++; if (current_frame !== 1'b0) begin n_fail++; $display("FAIL reset_current_frame: got %b, required 0", current_frame); end
        n_tests++; if (fb_address !== 15'd0) begin n_fail++; $display("FAIL reset_fb_address: got %0d, required 0", fb_address); end
        n_tests++; if (interrupt[0] === 1'b1) begin n_fail++; $display("FAIL reset_interrupt: got %b, required idle", interrupt); end
        bus_read(4'd11, rd);
        n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h, required 00", rd); end
        bus_read(4'd6, rd);
        n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_w_lo: got %h, required 00", rd); end
    endtask

    task automatic test_fill_basic();
        int go_cyc, c0, bad;
        bit ok;
        program_rect(1, 1, 2, 2, 8'h2A);
        model_rect(1, 1, 2, 2);
        start_cmd(1, go_cyc, c0);
        wait_irq(c0, 50, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL fill_basic_done: no interrupt within 50 cycles, required one"); end
        n_tests++; if (pix_addr.size() != 4) begin n_fail++; $display("FAIL fill_basic_count: got %0d, required 4", pix_addr.size()); end
        bad = first_bad(8'h2A);
        n_tests++; if (bad != -1) begin n_fail++; $display("FAIL fill_basic_pixels: first bad %0d, required none", bad); end
        if (pix_addr.size() == 4) begin
            n_tests++;
            if (pix_addr[0] != 161 || pix_addr[1] != 162 || pix_addr[2] != 321 || pix_addr[3] != 322) begin
                n_fail++;
                $display("FAIL fill_basic_addr: got %0d,%0d,%0d,%0d, required 161,162,321,322",
                         pix_addr[0], pix_addr[1], pix_addr[2], pix_addr[3]);
            end
            n_tests++; if (pix_cyc[0] != go_cyc + 2) begin n_fail++; $display("FAIL fill_basic_first: cycle %0d, required %0d", pix_cyc[0], go_cyc + 2); end
            n_tests++; if (pix_cyc[3] != pix_cyc[0] + 3) begin n_fail++; $display("FAIL fill_basic_b2b: last at %0d, required %0d", pix_cyc[3], pix_cyc[0] + 3); end
            n_tests++; if (irq_cyc != pix_cyc[3] + 1) begin n_fail++; $display("FAIL fill_basic_irq_cycle: got %0d, required %0d", irq_cyc, pix_cyc[3] + 1); end
        end
        repeat (5) @(negedge clk);
        #1;
        n_tests++; if (irq_cnt != c0 + 1) begin n_fail++; $display("FAIL fill_basic_irq_pulse: %0d pulses, required 1", irq_cnt - c0); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fill_basic_idle: busy %b, required 0", busy); end
    endtask

    task automatic test_fill_clip();
        int go_cyc, c0, bad;
        bit ok;
        program_rect(158, 119, 5, 4, 8'h81);
        model_rect(158, 119, 5, 4);
        start_cmd(1, go_cyc, c0);
        wait_irq(c0, 50, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL clip_done: no interrupt, required one"); end
        n_tests++;
        if (pix_addr.size() != 2 || pix_addr[0] != 19198 || pix_addr[1] != 19199) begin
            n_fail++;
            $display("FAIL clip_addr: got %0d writes, required 2 at 19198,19199", pix_addr.size());
        end
        bad = first_bad(8'h81);
        n_tests++; if (bad != -1) begin n_fail++; $display("FAIL clip_model: first bad %0d, required none", bad); end
    endtask

    task automatic test_empty();
        int go_cyc, c0;
        bit ok;
        program_rect(5, 5, 0, 3, 8'h11);
        start_cmd(1, go_cyc, c0);
        wait_irq(c0, 20, ok);
        n_tests++; if (!ok || irq_cyc != go_cyc + 2) begin n_fail++; $display("FAIL empty_w0_latency: irq at %0d, required %0d", irq_cyc, go_cyc + 2); end
        n_tests++; if (pix_addr.size() != 0) begin n_fail++; $display("FAIL empty_w0_writes: got %0d, required 0", pix_addr.size()); end
        program_rect(200, 3, 4, 4, 8'h11);
        start_cmd(1, go_cyc, c0);
        wait_irq(c0, 20, ok);
        n_tests++; if (!ok || pix_addr.size() != 0) begin n_fail++; $display("FAIL empty_x0_out: ok %0d writes %0d, required 1 and 0", ok, pix_addr.size()); end
    endtask

    task automatic test_stall();
        int go_cyc, c0, bad, s0;
        bit ok;
        ready_mode = 2;
        fb_ready = 1'b1;
        program_rect(10, 5, 4, 3, 8'h55);
        model_rect(10, 5, 4, 3);
        s0 = stall_err;
        start_cmd(1, go_cyc, c0);
        repeat (3) @(posedge clk);
        #1 fb_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 fb_ready = 1'b1;
        wait_irq(c0, 50, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL stall_done: no interrupt, required one"); end
        bad = first_bad(8'h55);
        n_tests++; if (bad != -1) begin n_fail++; $display("FAIL stall_pixels: first bad %0d (got %0d pixels), required none of 12", bad, pix_addr.size()); end
        n_tests++; if (stall_err != s0) begin n_fail++; $display("FAIL stall_stable: %0d unstable cycles, required 0", stall_err - s0); end
        ready_mode = 0;
    endtask

    task automatic test_go_busy();
        int go_cyc, c0, bad;
        bit ok;
        logic [7:0] rd;
        program_rect(0, 0, 40, 10, 8'h11);
        model_rect(0, 0, 40, 10);
        start_cmd(1, go_cyc, c0);
        repeat (5) @(negedge clk);
        bus_write(4'd2, 8'd50);
        bus_write(4'd1, 8'h00);
        bus_read(4'd11, rd);
        n_tests++; if (rd !== 8'h03) begin n_fail++; $display("FAIL go_busy_status: got %h, required 03", rd); end
        wait_irq(c0, 1000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL go_busy_done: no interrupt, required one"); end
        bad = first_bad(8'h11);
        n_tests++; if (bad != -1) begin n_fail++; $display("FAIL go_busy_pixels: first bad %0d (got %0d), required none of 400", bad, pix_addr.size()); end
        repeat (10) @(negedge clk);
        #1;
        n_tests++; if (irq_cnt != c0 + 1 || busy !== 1'b0) begin n_fail++; $display("FAIL go_busy_restart: %0d irqs busy %b, required 1 and 0", irq_cnt - c0, busy); end
        bus_write(4'd11, 8'h02);
        bus_read(4'd11, rd);
        n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL err_clear: got %h, required 00", rd); end
    endtask

    task automatic test_swap();
        int go_cyc, c0;
        logic cf0;
        cf0 = current_frame;
        start_cmd(0, go_cyc, c0);
        repeat (9) @(negedge clk);
        #1;
        n_tests++; if (current_frame !== cf0 || busy !== 1'b1 || irq_cnt != c0) begin
            n_fail++; $display("FAIL swap_wait: frame %b busy %b irqs %0d, required %b 1 0", current_frame, busy, irq_cnt - c0, cf0);
        end
        frame = 1'b1;
        @(posedge clk);
        #1 frame = 1'b0;
        @(negedge clk);
        #1;
        n_tests++; if (current_frame !== ~cf0) begin n_fail++; $display("FAIL swap_toggle: got %b, required %b", current_frame, ~cf0); end
        n_tests++; if (irq_cnt != c0 + 1 || irq_cyc != cyc) begin n_fail++; $display("FAIL swap_irq: irqs %0d at %0d, required 1 at %0d", irq_cnt - c0, irq_cyc, cyc); end
        @(negedge clk);
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL swap_idle: busy %b, required 0", busy); end

        // a frame pulse during SETUP must be ignored
        start_cmd(0, go_cyc, c0);
        frame = 1'b1;
        @(posedge clk);
        #1 frame = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_tests++; if (current_frame !== ~cf0 || busy !== 1'b1) begin n_fail++; $display("FAIL swap_setup_pulse: frame %b busy %b, required %b 1", current_frame, busy, ~cf0); end
        frame = 1'b1;
        @(posedge clk);
        #1 frame = 1'b0;
        @(negedge clk);
        #1;
        n_tests++; if (current_frame !== cf0 || irq_cnt != c0 + 1) begin n_fail++; $display("FAIL swap_second: frame %b irqs %0d, required %b 1", current_frame, irq_cnt - c0, cf0); end
    endtask

    task automatic test_bad_cmd();
        int go_cyc, c0;
        bit ok;
        logic [7:0] rd;
        start_cmd(7, go_cyc, c0);
        wait_irq(c0, 10, ok);
        n_tests++; if (!ok || pix_addr.size() != 0) begin n_fail++; $display("FAIL bad_cmd_done: ok %0d writes %0d, required 1 and 0", ok, pix_addr.size()); end
        bus_read(4'd11, rd);
        n_tests++; if (rd !== 8'h02) begin n_fail++; $display("FAIL bad_cmd_err: got %h, required 02", rd); end
        bus_write(4'd11, 8'h02);
    endtask

    task automatic test_clear();
        int go_cyc, c0, bad;
        bit ok;
        program_rect(30, 30, 2, 2, 8'h07);
        model_rect(0, 0, FBW, FBH);
        start_cmd(2, go_cyc, c0);
        wait_irq(c0, 25000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL clear_done: no interrupt, required one"); end
        bad = first_bad(8'h07);
        n_tests++; if (bad != -1) begin n_fail++; $display("FAIL clear_pixels: first bad %0d (got %0d), required none of 19200", bad, pix_addr.size()); end
    endtask

    task automatic test_random();
        int go_cyc, c0, bad, x0, y0, w, h, col;
        bit ok;
        ready_mode = 1;
        for (int i = 0; i < 10; i++) begin
            x0  = (i % 3 == 0) ? int'($urandom_range(150, 165)) : int'($urandom_range(0, 170));
            y0  = (i % 3 == 1) ? int'($urandom_range(110, 122)) : int'($urandom_range(0, 125));
            w   = $urandom_range(0, 12);
            h   = $urandom_range(0, 8);
            col = $urandom_range(0, 255);
            program_rect(x0, y0, w, h, col);
            model_rect(x0, y0, w, h);
            start_cmd(1, go_cyc, c0);
            wait_irq(c0, 2000, ok);
            bad = first_bad(col);
            n_tests++;
            if (!ok || bad != -1) begin
                n_fail++;
                $display("FAIL random[%0d] (%0d,%0d,%0d,%0d): done %0d first bad %0d, got %0d pixels, required %0d",
                         i, x0, y0, w, h, ok, bad, pix_addr.size(), exp_addr.size());
            end
        end
        ready_mode = 0;
    endtask

    task automatic test_reset_mid_fill();
        int go_cyc, c0, n;
        logic [7:0] rd;
        program_rect(0, 0, 100, 10, 8'h33);
        start_cmd(1, go_cyc, c0);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n = pix_addr.size();
        repeat (30) @(negedge clk);
        #1;
        n_tests++; if (pix_addr.size() != n || n == 0 || n >= 1000) begin n_fail++; $display("FAIL reset_abort_writes: %0d before, %0d after, required equal and partial", n, pix_addr.size()); end
        n_tests++; if (irq_cnt != c0 || busy !== 1'b0 || fb_we !== 1'b0) begin n_fail++; $display("FAIL reset_abort_state: irqs %0d busy %b we %b, required 0 0 0", irq_cnt - c0, busy, fb_we); end
        bus_read(4'd6, rd);
        n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_abort_regs: w_lo %h, required 00", rd); end
    endtask

    initial begin
        test_reset();
        test_fill_basic();
        test_fill_clip();
        test_empty();
        test_stall();
        test_go_busy();
        test_swap();
        test_bad_cmd();
        test_clear();
        test_random();
        test_reset_mid_fill();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
